// File: rtl/descriptor_receive_queue_if.sv
// Descriptor receive queue handshake bundle.
// master: sender/consumer side, slave: the queue.
interface descriptor_receive_queue_if;
    logic [45:0] iv_descriptor;
    logic        i_descriptor_wr;
    logic        o_descriptor_ack;
    logic [45:0] ov_descriptor;
    logic        o_descriptor_valid;
    logic        i_descriptor_rd;
    logic [2:0]  ov_queue_usedw;
    logic [15:0] ov_rcv_cnt;

    modport master (
        output iv_descriptor,
        output i_descriptor_wr,
        output i_descriptor_rd,
        input  o_descriptor_ack,
        input  ov_descriptor,
        input  o_descriptor_valid,
        input  ov_queue_usedw,
        input  ov_rcv_cnt
    );

    modport slave (
        input  iv_descriptor,
        input  i_descriptor_wr,
        input  i_descriptor_rd,
        output o_descriptor_ack,
        output ov_descriptor,
        output o_descriptor_valid,
        output ov_queue_usedw,
        output ov_rcv_cnt
    );
endinterface

// File: rtl/descriptor_receive_queue.sv
// Four-entry first-word-fall-through descriptor queue
// with a level-request / pulse-ack receive handshake.
module descriptor_receive_queue (
    input logic                          i_clk,
    input logic                          i_rst,
    descriptor_receive_queue_if.slave    q
);
    typedef enum logic {IDLE_S, ACK_S} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wr_acc;
    logic        pop;
    logic [45:0] mem [4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  usedw;
    logic        ack;
    logic [15:0] cnt;

    // Full-ness uses registered usedw only, so a same-cycle pop never
    // makes room for a write.
    assign pop = q.i_descriptor_rd && (usedw != 3'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE_S;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE_S;
        wr_acc    = 1'b0;
        case (state)
            IDLE_S: begin
                if (q.i_descriptor_wr && (usedw < 3'd4)) begin
                    wr_acc    = 1'b1;
                    state_nxt = ACK_S;
                end
            end
            ACK_S:   state_nxt = IDLE_S;
            default: state_nxt = IDLE_S;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            usedw <= 3'd0;
            ack   <= 1'b0;
            cnt   <= 16'd0;
        end else begin
            ack   <= wr_acc;
            usedw <= usedw + {2'b0, wr_acc} - {2'b0, pop};
            cnt   <= cnt + {15'b0, wr_acc};
            if (wr_acc) tail <= tail + 2'd1;
            if (pop)    head <= head + 2'd1;
        end
    end

    // Storage needs no reset; stale entries are hidden by usedw.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) mem[tail] <= q.iv_descriptor;
    end

    assign q.o_descriptor_ack   = ack;
    assign q.o_descriptor_valid = (usedw != 3'd0);
    assign q.ov_descriptor      = (usedw != 3'd0) ? mem[head] : 46'h0;
    assign q.ov_queue_usedw     = usedw;
    assign q.ov_rcv_cnt         = cnt;
endmodule

// File: doc/descriptor_receive_queue.md
DESCRIPTOR_RECEIVE_QUEUE -- requirements
Module: descriptor_receive_queue

Interface
REQ-001 Parameters: none; queue depth fixed at 4 entries of 46 bits.
REQ-002 i_clk  input  1  125 MHz clock; all logic on rising edge; single clock domain.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 iv_descriptor  input  46  descriptor from upstream sender; valid while i_descriptor_wr=1.
REQ-005 i_descriptor_wr  input  1  level request; sender holds it high until it samples o_descriptor_ack=1, then drops it on that same edge.
REQ-006 o_descriptor_ack  output  1  registered one-cycle accept pulse to sender.
REQ-007 ov_descriptor  output  46  head-of-queue descriptor (first-word-fall-through).
REQ-008 o_descriptor_valid  output  1  1 when queue non-empty.
REQ-009 i_descriptor_rd  input  1  downstream pop; acts only when o_descriptor_valid=1.
REQ-010 ov_queue_usedw  output  3  occupancy 0..4.
REQ-011 ov_rcv_cnt  output  16  count of accepted descriptors.

Function
REQ-012 Receive FSM states: IDLE_S, ACK_S; encoding 1 bit or 2 bits, unused codes return to IDLE_S.
REQ-013 IDLE_S: if i_descriptor_wr=1 and usedw<4 -> write iv_descriptor at tail, o_descriptor_ack<=1, go ACK_S; else ack<=0, stay.
REQ-014 ACK_S: o_descriptor_ack<=0, i_descriptor_wr ignored (sender still drives it high this cycle), go IDLE_S unconditionally.
REQ-015 Exactly one queue write per ack pulse; maximum accept rate one descriptor per 2 cycles.
REQ-016 Latency: wr sampled at edge N -> ack high in cycle N..N+1, descriptor visible on ov_descriptor/o_descriptor_valid in cycle after edge N.
REQ-017 Full (usedw=4): no ack, no write; request stays pending; accepted in first IDLE_S cycle where usedw<4 at the sampling edge.
REQ-018 Full-ness is evaluated from current registered usedw; a pop in the same cycle does not free space for a write in that cycle (no bypass).
REQ-019 Pop: i_descriptor_rd=1 and valid=1 -> head pointer advances at edge; i_descriptor_rd with queue empty is ignored, no pointer/usedw change.
REQ-020 Simultaneous write and pop (usedw 1..3): both performed, usedw unchanged.
REQ-021 Write with usedw=0 and pop same cycle: pop ignored (valid=0), write performed, usedw -> 1.
REQ-022 Pointers 2-bit, wrap 3->0; usedw 3-bit, never exceeds 4 nor underflows.
REQ-023 ov_descriptor equals entry at head pointer when valid=1; value when valid=0 is 46'h0.
REQ-024 ov_rcv_cnt increments by 1 per accepted descriptor, wraps 16'hFFFF -> 0.

Reset
REQ-025 i_rst=1 at any edge: FSM -> IDLE_S, o_descriptor_ack=0, pointers=0, usedw=0, o_descriptor_valid=0, ov_descriptor=46'h0, ov_rcv_cnt=0; stored entries discarded.
REQ-026 Reset asserted while in ACK_S or with pending wr: no write occurs at that edge; after release, a still-high wr is treated as a new request.

Verification
REQ-027 Single transfer: wr=1 with descriptor 46'h1_2345_6789 at empty queue -> ack pulse exactly 1 cycle, valid=1, ov_descriptor=46'h1_2345_6789, usedw=1, rcv_cnt=1.
REQ-028 Held wr through ack cycle (sender drops it on ack edge) -> exactly one entry written, usedw=1, no second ack.
REQ-029 Fill: 5 back-to-back requests, no pops -> 4 acks, usedw=4, 5th wr held without ack; one pop -> 5th accepted next IDLE_S cycle, usedw returns to 4, order preserved.
REQ-030 Wrap: 10 descriptors with interleaved pops -> output order equals input order across pointer wrap, usedw never >4.
REQ-031 Pop on empty with rd=1 for 3 cycles -> usedw stays 0, valid stays 0, pointers unchanged.
REQ-032 Reset mid-operation with usedw=3 and ack high -> next cycle ack=0, valid=0, usedw=0, rcv_cnt=0.
